// File: rtl/data_memory_pkg.sv
// Shared constants and types for the data memory: size codes, dump FSM states,
// and a lane-mask expansion helper.
package data_memory_pkg;

  localparam int unsigned NB_LANE = 8;

  // Size codes follow the formatter's {word, half, byte} ordering.
  localparam logic [2:0] SIZE_BYTE = 3'b001;
  localparam logic [2:0] SIZE_HALF = 3'b010;
  localparam logic [2:0] SIZE_WORD = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DUMP = 2'd1,
    DONE = 2'd2
  } dump_state_e;

  function automatic logic [4*NB_LANE-1:0] lane_bits(input logic [3:0] mask);
    logic [4*NB_LANE-1:0] bits;
    bits = '0;
    for (int l = 0; l < 4; l++) begin
      bits[l*NB_LANE +: NB_LANE] = {NB_LANE{mask[l]}};
    end
    return bits;
  endfunction

endpackage

// File: rtl/data_mem_lane_decode.sv
// Combinational size/offset decode: byte-lane mask, bit shift to right-align
// the access, and an illegal-access flag.
module data_mem_lane_decode
  import data_memory_pkg::*;
(
  input  logic [2:0] i_size,
  input  logic [1:0] i_offset,
  output logic [3:0] o_lane_mask,
  output logic [4:0] o_shift,
  output logic       o_misaligned
);

  always_comb begin
    o_lane_mask  = 4'b0000;
    o_shift      = 5'd0;
    o_misaligned = 1'b0;
    unique case (i_size)
      SIZE_WORD: begin
        if (i_offset != 2'b00) begin
          o_misaligned = 1'b1;
        end else begin
          o_lane_mask = 4'b1111;
        end
      end
      SIZE_HALF: begin
        if (i_offset[0]) begin
          o_misaligned = 1'b1;
        end else if (i_offset[1]) begin
          o_lane_mask = 4'b1100;
          o_shift     = 5'd16;
        end else begin
          o_lane_mask = 4'b0011;
        end
      end
      SIZE_BYTE: begin
        o_lane_mask = 4'b0001 << i_offset;
        o_shift     = {i_offset, 3'b000};
      end
      // Any code that is not one-hot is rejected outright.
      default: o_misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Word-organised data memory with byte-lane stores, right-aligned registered
// loads, and a handshaked dump port for streaming contents while halted.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_ADDR = 7
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_mem_read,
  input  logic               i_mem_write,
  input  logic               i_word_en,
  input  logic               i_halfword_en,
  input  logic               i_byte_en,
  input  logic [NB_ADDR-1:0] i_addr,
  input  logic [NB_DATA-1:0] i_write_data,
  output logic [NB_DATA-1:0] o_read_data,
  output logic               o_misaligned,
  input  logic               i_dump_start,
  input  logic               i_dump_ready,
  output logic               o_dump_valid,
  output logic [NB_ADDR-3:0] o_dump_addr,
  output logic [NB_DATA-1:0] o_dump_data,
  output logic               o_dump_done,
  output logic               o_busy
);

  localparam int unsigned NB_WIDX = NB_ADDR - 2;
  localparam int unsigned DEPTH   = 1 << NB_WIDX;
  localparam logic [NB_WIDX-1:0] LAST_IDX = NB_WIDX'(DEPTH - 1);

  logic [NB_DATA-1:0] r_mem [DEPTH];

  logic [2:0]         w_size;
  logic [NB_WIDX-1:0] w_widx;
  logic [3:0]         w_lane_mask;
  logic [4:0]         w_shift;
  logic               w_misaligned;
  logic [NB_DATA-1:0] w_bitmask;
  logic [NB_DATA-1:0] w_wdata_aligned;
  logic [NB_DATA-1:0] w_rd_aligned;
  logic               w_write_en;
  logic               w_busy;

  assign w_size = {i_word_en, i_halfword_en, i_byte_en};
  assign w_widx = i_addr[NB_ADDR-1:2];

  data_mem_lane_decode u_lane_decode (
    .i_size       (w_size),
    .i_offset     (i_addr[1:0]),
    .o_lane_mask  (w_lane_mask),
    .o_shift      (w_shift),
    .o_misaligned (w_misaligned)
  );

  assign w_bitmask       = lane_bits(w_lane_mask);
  assign w_wdata_aligned = i_write_data << w_shift;
  assign w_rd_aligned    = (r_mem[w_widx] & w_bitmask) >> w_shift;
  assign w_write_en      = i_mem_write & ~w_misaligned & ~w_busy;

  // Array is not reset; only enabled lanes are touched.
  always_ff @(posedge i_clock) begin
    if (w_write_en) begin
      for (int l = 0; l < 4; l++) begin
        if (w_lane_mask[l]) begin
          r_mem[w_widx][l*NB_LANE +: NB_LANE] <= w_wdata_aligned[l*NB_LANE +: NB_LANE];
        end
      end
    end
  end

  logic [NB_DATA-1:0] r_read_data;
  logic               r_misaligned;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_read_data  <= '0;
      r_misaligned <= 1'b0;
    end else begin
      if (i_mem_read) begin
        r_read_data <= w_misaligned ? '0 : w_rd_aligned;
      end
      r_misaligned <= (i_mem_read | i_mem_write) & w_misaligned;
    end
  end

  assign o_read_data  = r_read_data;
  assign o_misaligned = r_misaligned;

  dump_state_e        r_state, w_state_next;
  logic [NB_WIDX-1:0] r_ptr, w_ptr_next, w_ptr_inc;
  logic               r_dump_valid, w_dump_valid_next;
  logic [NB_DATA-1:0] r_dump_data, w_dump_data_next;
  logic               r_dump_done, w_dump_done_next;

  assign w_ptr_inc = r_ptr + 1'b1;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_dump_valid <= 1'b0;
      r_dump_data  <= '0;
      r_dump_done  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_ptr        <= w_ptr_next;
      r_dump_valid <= w_dump_valid_next;
      r_dump_data  <= w_dump_data_next;
      r_dump_done  <= w_dump_done_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_ptr_next        = r_ptr;
    w_dump_valid_next = r_dump_valid;
    w_dump_data_next  = r_dump_data;
    w_dump_done_next  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_dump_start) begin
          w_state_next      = DUMP;
          w_ptr_next        = '0;
          w_dump_valid_next = 1'b1;
          w_dump_data_next  = r_mem[0];
        end
      end
      DUMP: begin
        if (r_dump_valid && i_dump_ready) begin
          if (r_ptr == LAST_IDX) begin
            w_state_next      = DONE;
            w_dump_valid_next = 1'b0;
            w_dump_done_next  = 1'b1;
          end else begin
            // Load the next word on the accepting edge for bubble-free streaming.
            w_ptr_next       = w_ptr_inc;
            w_dump_data_next = r_mem[w_ptr_inc];
          end
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign w_busy       = (r_state != IDLE);
  assign o_busy       = w_busy;
  assign o_dump_valid = r_dump_valid;
  assign o_dump_addr  = r_ptr;
  assign o_dump_data  = r_dump_data;
  assign o_dump_done  = r_dump_done;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: vector table for load/store paths, plus
// hand-written dump, backpressure and mid-dump reset sequences.
module tb_data_memory;

  logic        clk;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic        word_en, half_en, byte_en;
  logic [6:0]  addr;
  logic [31:0] wdata;
  logic [31:0] read_data;
  logic        misaligned;
  logic        dump_start, dump_ready;
  logic        dump_valid;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;
  logic        dump_done;
  logic        busy;

  int tests_run;
  int tests_failed;

  data_memory #(.NB_DATA(32), .NB_ADDR(7)) dut (
    .i_clock       (clk),
    .i_reset       (rst_n),
    .i_mem_read    (mem_read),
    .i_mem_write   (mem_write),
    .i_word_en     (word_en),
    .i_halfword_en (half_en),
    .i_byte_en     (byte_en),
    .i_addr        (addr),
    .i_write_data  (wdata),
    .o_read_data   (read_data),
    .o_misaligned  (misaligned),
    .i_dump_start  (dump_start),
    .i_dump_ready  (dump_ready),
    .o_dump_valid  (dump_valid),
    .o_dump_addr   (dump_addr),
    .o_dump_data   (dump_data),
    .o_dump_done   (dump_done),
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  size;  // {word, half, byte}
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_mis;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs[NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] size,
                       input logic [6:0] a, input logic [31:0] d);
    mem_read  = rd;
    mem_write = wr;
    {word_en, half_en, byte_en} = size;
    addr  = a;
    wdata = d;
  endtask

  task automatic idle_bus();
    drive(1'b0, 1'b0, 3'b000, 7'h00, 32'h0);
  endtask

  initial begin
    int exp_idx;
    int c;
    logic [3:0] pat;

    tests_run    = 0;
    tests_failed = 0;
    rst_n      = 1'b0;
    dump_start = 1'b0;
    dump_ready = 1'b0;
    idle_bus();

    vecs[0]  = '{1'b0, 1'b1, 3'b100, 7'h08, 32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 3'b100, 7'h08, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 3'b001, 7'h0B, 32'h0000005A, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 3'b100, 7'h08, 32'h0,        32'h5AADBEEF, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 3'b001, 7'h0B, 32'h0,        32'h0000005A, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 3'b010, 7'h0A, 32'h00001234, 32'h0000005A, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 3'b010, 7'h0A, 32'h0,        32'h00001234, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 3'b010, 7'h09, 32'h0000ABCD, 32'h00001234, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 3'b100, 7'h08, 32'h0,        32'h1234BEEF, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 3'b100, 7'h10, 32'h00000000, 32'h1234BEEF, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 3'b100, 7'h10, 32'h11111111, 32'h00000000, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 3'b100, 7'h10, 32'h0,        32'h11111111, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 3'b100, 7'h06, 32'h0,        32'h00000000, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 3'b011, 7'h08, 32'h0,        32'h00000000, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 3'b001, 7'h09, 32'h0,        32'h000000BE, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 3'b010, 7'h08, 32'h0,        32'h0000BEEF, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 3'b000, 7'h08, 32'h0,        32'h0000BEEF, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 3'b001, 7'h08, 32'hFFFFFF77, 32'h0000BEEF, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 3'b100, 7'h08, 32'h0,        32'h1234BE77, 1'b0};

    #12;
    chk("reset read_data", read_data, 32'h0);
    chk("reset misaligned", {31'h0, misaligned}, 32'h0);
    chk("reset dump_valid", {31'h0, dump_valid}, 32'h0);
    chk("reset dump_done", {31'h0, dump_done}, 32'h0);
    chk("reset busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].rd, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d read_data", i), read_data, vecs[i].exp_rd);
      chk($sformatf("vec%0d misaligned", i), {31'h0, misaligned}, {31'h0, vecs[i].exp_mis});
    end

    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 3'b100, 7'(i * 4), 32'(i * 3));
    end
    @(negedge clk);
    idle_bus();

    // Full dump with ready held high.
    dump_start = 1'b1;
    dump_ready = 1'b1;
    @(posedge clk);
    #1;
    dump_start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      chk($sformatf("dump%0d valid", k), {31'h0, dump_valid}, 32'h1);
      chk($sformatf("dump%0d addr", k), {27'h0, dump_addr}, 32'(k));
      chk($sformatf("dump%0d data", k), dump_data, 32'(k * 3));
      chk($sformatf("dump%0d busy", k), {31'h0, busy}, 32'h1);
      chk($sformatf("dump%0d done", k), {31'h0, dump_done}, 32'h0);
      if (k == 10) drive(1'b0, 1'b1, 3'b100, 7'h04, 32'hFFFFFFFF);
      @(posedge clk);
      #1;
      idle_bus();
    end
    chk("dump end valid", {31'h0, dump_valid}, 32'h0);
    chk("dump end done", {31'h0, dump_done}, 32'h1);
    chk("dump end busy", {31'h0, busy}, 32'h1);
    @(posedge clk);
    #1;
    chk("after done pulse", {31'h0, dump_done}, 32'h0);
    chk("after done busy", {31'h0, busy}, 32'h0);

    @(negedge clk);
    drive(1'b1, 1'b0, 3'b100, 7'h04, 32'h0);
    @(posedge clk);
    #1;
    chk("write during dump dropped", read_data, 32'h3);
    @(negedge clk);
    idle_bus();

    // Backpressure with ready pattern 1,0,0,1 repeating, then reset at index 5.
    pat = 4'b1001;
    dump_ready = 1'b0;
    dump_start = 1'b1;
    @(posedge clk);
    #1;
    dump_start = 1'b0;
    exp_idx = 0;
    chk("bp start addr", {27'h0, dump_addr}, 32'h0);
    chk("bp start valid", {31'h0, dump_valid}, 32'h1);
    c = 0;
    while (c < 40 && exp_idx < 5) begin
      @(negedge clk);
      dump_ready = pat[3 - (c % 4)];
      @(posedge clk);
      #1;
      if (dump_ready) exp_idx++;
      chk($sformatf("bp%0d addr", c), {27'h0, dump_addr}, 32'(exp_idx));
      chk($sformatf("bp%0d data", c), dump_data, 32'(exp_idx * 3));
      chk($sformatf("bp%0d valid", c), {31'h0, dump_valid}, 32'h1);
      c++;
    end
    chk("bp reached index 5", 32'(exp_idx), 32'h5);

    #2;
    rst_n = 1'b0;
    #1;
    chk("mid-dump reset valid", {31'h0, dump_valid}, 32'h0);
    chk("mid-dump reset busy", {31'h0, busy}, 32'h0);
    chk("mid-dump reset addr", {27'h0, dump_addr}, 32'h0);
    dump_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("no done after reset %0d", k), {31'h0, dump_done}, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
